// File: rtl/transmitter_control_unit_if.sv
// Host and clock-counter signal bundle for transmitter_control_unit.
// o_state_is_PARITY exists only when TRANSMITTER_PARITY_EN is defined.
interface transmitter_control_unit_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_start;
  logic [DATA_BITS-1:0] i_data;
  logic                 i_equal;
  logic                 o_state_is_START;
  logic                 o_state_is_DATA;
  logic                 o_state_is_STOP;
`ifdef TRANSMITTER_PARITY_EN
  logic                 o_state_is_PARITY;
`endif
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_done;

`ifdef TRANSMITTER_PARITY_EN
  modport master (
    output i_start, i_data, i_equal,
    input  o_state_is_START, o_state_is_DATA, o_state_is_STOP, o_state_is_PARITY,
    input  o_tx, o_busy, o_done
  );
  modport slave (
    input  i_start, i_data, i_equal,
    output o_state_is_START, o_state_is_DATA, o_state_is_STOP, o_state_is_PARITY,
    output o_tx, o_busy, o_done
  );
`else
  modport master (
    output i_start, i_data, i_equal,
    input  o_state_is_START, o_state_is_DATA, o_state_is_STOP,
    input  o_tx, o_busy, o_done
  );
  modport slave (
    input  i_start, i_data, i_equal,
    output o_state_is_START, o_state_is_DATA, o_state_is_STOP,
    output o_tx, o_busy, o_done
  );
`endif
endinterface

// File: rtl/transmitter_control_unit.sv
// UART transmit FSM and shift path (IDLE/START/DATA/STOP, one-hot, all outputs registered).
// Optional PARITY state between DATA and STOP is built when TRANSMITTER_PARITY_EN is defined.
module transmitter_control_unit #(
  parameter int DATA_BITS         = 8,
  parameter int BIT_COUNTER_WIDTH = 3
) (
  input logic                       i_clock,
  input logic                       i_resetL,
  transmitter_control_unit_if.slave bus
);

`ifdef TRANSMITTER_PARITY_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
  localparam int STOP_IDX = 4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;
  localparam int STOP_IDX = 3;
`endif

  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_IDX = BIT_COUNTER_WIDTH'(DATA_BITS - 1);

  state_t                       state_r, state_s;
  logic [DATA_BITS-1:0]         shift_r, shift_s;
  logic [BIT_COUNTER_WIDTH-1:0] idx_r, idx_s;
  logic                         tx_r, tx_s;
  logic                         busy_r, busy_s;
  logic                         done_r, done_s;
`ifdef TRANSMITTER_PARITY_EN
  logic                         parity_r, parity_s;
`endif

  // Next-state, datapath update and next-output decode.
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    idx_s    = idx_r;
    done_s   = 1'b0;
`ifdef TRANSMITTER_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.i_start) begin
          shift_s  = bus.i_data;
          idx_s    = {BIT_COUNTER_WIDTH{1'b0}};
`ifdef TRANSMITTER_PARITY_EN
          parity_s = even_parity(bus.i_data);
`endif
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: begin
        if (bus.i_equal) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        // The last data bit is held in place rather than shifted out.
        if (bus.i_equal) begin
          if (idx_r == LAST_IDX) begin
`ifdef TRANSMITTER_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
            idx_s   = idx_r + BIT_COUNTER_WIDTH'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef TRANSMITTER_PARITY_EN
      PARITY: begin
        if (bus.i_equal) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bus.i_equal) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Line level is decoded from the upcoming state so it can be registered.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef TRANSMITTER_PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_r  <= IDLE;
      shift_r  <= {DATA_BITS{1'b0}};
      idx_r    <= {BIT_COUNTER_WIDTH{1'b0}};
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef TRANSMITTER_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      idx_r    <= idx_s;
      tx_r     <= tx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef TRANSMITTER_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  assign bus.o_state_is_START  = state_r[1];
  assign bus.o_state_is_DATA   = state_r[2];
  assign bus.o_state_is_STOP   = state_r[STOP_IDX];
`ifdef TRANSMITTER_PARITY_EN
  assign bus.o_state_is_PARITY = state_r[3];
`endif
  assign bus.o_tx              = tx_r;
  assign bus.o_busy            = busy_r;
  assign bus.o_done            = done_r;

endmodule

// File: tb/tb_transmitter_control_unit.sv
// Self-checking bench: frame-level symbol model compared every cycle, plus literal frame checks.
module tb_transmitter_control_unit;
  localparam int DB = 8;
`ifdef TRANSMITTER_PARITY_EN
  localparam int NSYM = DB + 3;
  localparam logic [NSYM-1:0] EXP_A5 = 11'b01010010101;
  localparam logic [NSYM-1:0] EXP_3C = 11'b00011110001;
  localparam logic [NSYM-1:0] EXP_01 = 11'b01000000011;
  localparam logic [NSYM-1:0] EXP_80 = 11'b00000000111;
  localparam logic [NSYM-1:0] EXP_07 = 11'b01110000011;
`else
  localparam int NSYM = DB + 2;
  localparam logic [NSYM-1:0] EXP_A5 = 10'b0101001011;
  localparam logic [NSYM-1:0] EXP_3C = 10'b0001111001;
  localparam logic [NSYM-1:0] EXP_01 = 10'b0100000001;
  localparam logic [NSYM-1:0] EXP_80 = 10'b0000000011;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  transmitter_control_unit_if #(.DATA_BITS(DB)) bus();

  transmitter_control_unit #(.DATA_BITS(DB), .BIT_COUNTER_WIDTH(3)) dut (
    .i_clock (clk),
    .i_resetL(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock-counter stub: one-cycle i_equal every 4 cycles.
  initial begin
    int c;
    c = 0;
    bus.i_equal = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      bus.i_equal = ((c % 4) == 0);
    end
  end

  // Frame model: a symbol list plus position; a frame is busy while a symbol is on the line.
  bit              sym [NSYM];
  bit              m_busy = 1'b0;
  int              m_pos = 0;
  bit              new_sym;
  logic [NSYM-1:0] line_log = '0;
  int              done_cnt = 0;
  int              par_cycles = 0;

  always @(posedge clk) begin
    new_sym = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pos  = 0;
    end else if (!m_busy) begin
      if (bus.i_start) begin
        sym[0] = 1'b0;
        for (int i = 0; i < DB; i++) sym[1+i] = bus.i_data[i];
`ifdef TRANSMITTER_PARITY_EN
        sym[DB+1] = ^bus.i_data;
`endif
        sym[NSYM-1] = 1'b1;
        m_busy  = 1'b1;
        m_pos   = 0;
        new_sym = 1'b1;
      end
    end else if (bus.i_equal) begin
      if (m_pos == NSYM - 1) begin
        m_busy = 1'b0;
        done_cnt++;
      end else begin
        m_pos++;
        new_sym = 1'b1;
      end
    end
    #1;
    chk("tx",    bus.o_tx,             m_busy ? sym[m_pos] : 1'b1);
    chk("busy",  bus.o_busy,           m_busy);
    chk("start", bus.o_state_is_START, m_busy && m_pos == 0);
    chk("data",  bus.o_state_is_DATA,  m_busy && m_pos >= 1 && m_pos <= DB);
    chk("stop",  bus.o_state_is_STOP,  m_busy && m_pos == NSYM - 1);
`ifdef TRANSMITTER_PARITY_EN
    chk("parity_state", bus.o_state_is_PARITY, m_busy && m_pos == DB + 1);
    if (bus.o_state_is_PARITY) par_cycles++;
`endif
    if (new_sym) begin
      if (m_pos == 0) line_log = '0;
      line_log = {line_log[NSYM-2:0], bus.o_tx};
    end
  end

  // Count DUT done pulses separately so done_cnt (model) and dut_done can be compared.
  int dut_done = 0;
  always @(negedge clk) if (bus.o_done) dut_done++;

  task automatic send(input logic [DB-1:0] d);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    int d0;
    int busy_seen;
    bit ok;
    bus.i_start = 1'b0;
    bus.i_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    bus.o_tx,             1'b1);
    chk("rst_busy",  bus.o_busy,           1'b0);
    chk("rst_done",  bus.o_done,           1'b0);
    chk("rst_start", bus.o_state_is_START, 1'b0);
    chk("rst_data",  bus.o_state_is_DATA,  1'b0);
    chk("rst_stop",  bus.o_state_is_STOP,  1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 frame
    d0 = dut_done;
    send(8'hA5);
    wait_done("a5_done_timeout");
    chk("a5_line", line_log, EXP_A5);
    repeat (6) @(negedge clk);
    chk("a5_done_count", dut_done - d0, 1);

    // 0x3C with ignored mid-frame request
    d0 = dut_done;
    send(8'h3C);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.o_state_is_DATA) begin
        ok = 1'b1;
        break;
      end
    end
    chk("3c_reach_data", ok, 1'b1);
    bus.i_data  = 8'hFF;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done("3c_done_timeout");
    chk("3c_line", line_log, EXP_3C);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_busy) busy_seen++;
    end
    chk("3c_no_second_frame", busy_seen, 0);
    chk("3c_done_count", dut_done - d0, 1);

    // Back-to-back 0x01 then 0x80 accepted in the done cycle
    send(8'h01);
    wait_done("01_done_timeout");
    chk("01_line", line_log, EXP_01);
    bus.i_start = 1'b1;
    bus.i_data  = 8'h80;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("b2b_start", bus.o_state_is_START, 1'b1);
    chk("b2b_busy",  bus.o_busy,           1'b1);
    chk("b2b_tx",    bus.o_tx,             1'b0);
    wait_done("80_done_timeout");
    chk("80_line", line_log, EXP_80);

    // Reset during data bit 3 of 0x55
    repeat (3) @(negedge clk);
    d0 = dut_done;
    send(8'h55);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_busy && m_pos == 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("55_reach_bit3", ok, 1'b1);
    chk("55_bit3_low", bus.o_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",   bus.o_tx,             1'b1);
    chk("mid_rst_busy", bus.o_busy,           1'b0);
    chk("mid_rst_data", bus.o_state_is_DATA,  1'b0);
    chk("mid_rst_stop", bus.o_state_is_STOP,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_busy) busy_seen++;
    end
    chk("mid_rst_idle", busy_seen, 0);
    chk("mid_rst_no_done", dut_done - d0, 0);

`ifdef TRANSMITTER_PARITY_EN
    d0 = par_cycles;
    send(8'hA5);
    wait_done("pa5_done_timeout");
    chk("pa5_line", line_log, EXP_A5);
    chk("pa5_parity_len", par_cycles - d0, 4);
    send(8'h07);
    wait_done("p07_done_timeout");
    chk("p07_line", line_log, EXP_07);
`endif

    chk("done_model_vs_dut", dut_done, done_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
